// File: rtl/alu_operand_entry_if.sv
// Operation bus between the operand entry front end and the ALU.
// The entry block drives the operands/opcode and valid; the ALU side returns ready.
interface alu_operand_entry_if;
  logic [31:0] porta;
  logic [31:0] portb;
  logic [3:0]  aluop;
  logic        op_valid;
  logic        op_ready;

  modport master (
    output porta,
    output portb,
    output aluop,
    output op_valid,
    input  op_ready
  );

  modport slave (
    input  porta,
    input  portb,
    input  aluop,
    input  op_valid,
    output op_ready
  );
endinterface

// File: rtl/alu_operand_entry.sv
// Board key/switch front end for the ALU test harness: synchronizes and
// debounces keys, sequences A/B/opcode captures and issues them with valid/ready.
//
// state  | meaning
// CAP_A  | waiting for ENTER to capture operand A
// CAP_B  | waiting for ENTER to capture operand B
// CAP_OP | waiting for ENTER to capture the opcode and raise op_valid
// ISSUE  | op_valid high, waiting for op_ready (ENTER ignored)
module alu_operand_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [3:0]          KEY,
  input  logic [17:0]         SW,
  alu_operand_entry_if.master alu,
  output logic [1:0]          stage,
  output logic [3:0]          key_evt
);

  typedef enum logic [1:0] {
    CAP_A  = 2'b00,
    CAP_B  = 2'b01,
    CAP_OP = 2'b10,
    ISSUE  = 2'b11
  } state_t;

  logic [3:0]            key_s1_q, key_s2_q;
  logic [16:0]           sw_s1_q, sw_s2_q;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]            stable_q, stable_d;
  logic [3:0]            stable_dly_q;
  logic [3:0]            key_evt_q;

  state_t      state_q, state_d;
  logic [31:0] porta_q, porta_d;
  logic [31:0] portb_q, portb_d;
  logic [3:0]  aluop_q, aluop_d;
  logic        valid_q, valid_d;

  logic        enter, clear;
  logic [31:0] operand;
  logic        unused_sw17;

  assign unused_sw17 = SW[17];

  // Two-flop synchronizers; keys park at the released level while in reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      key_s1_q <= 4'hF;
      key_s2_q <= 4'hF;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      key_s1_q <= KEY;
      key_s2_q <= key_s1_q;
      sw_s1_q  <= SW[16:0];
      sw_s2_q  <= sw_s1_q;
    end
  end

  // Per-key debounce: the stable level flips only after DEBOUNCE_CYCLES differing samples.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < 4; i++) begin
      if (key_s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce state plus a one-cycle delayed copy used to spot press edges.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q        <= '0;
      stable_q     <= 4'hF;
      stable_dly_q <= 4'hF;
      key_evt_q    <= '0;
    end else begin
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      key_evt_q    <= stable_dly_q & ~stable_q;
    end
  end

  assign enter   = key_evt_q[0];
  assign clear   = key_evt_q[3];
  assign operand = {{16{sw_s2_q[16]}}, sw_s2_q[15:0]};

  // Capture sequencing; CLEAR overrides everything and leaves captured values intact.
  always_comb begin
    state_d = state_q;
    porta_d = porta_q;
    portb_d = portb_q;
    aluop_d = aluop_q;
    valid_d = valid_q;
    if (clear) begin
      valid_d = 1'b0;
      state_d = CAP_A;
    end else begin
      case (state_q)
        CAP_A: if (enter) begin
          porta_d = operand;
          state_d = CAP_B;
        end
        CAP_B: if (enter) begin
          portb_d = operand;
          state_d = CAP_OP;
        end
        CAP_OP: if (enter) begin
          aluop_d = sw_s2_q[3:0];
          valid_d = 1'b1;
          state_d = ISSUE;
        end
        ISSUE: if (valid_q && alu.op_ready) begin
          valid_d = 1'b0;
          state_d = CAP_A;
        end
        default: state_d = CAP_A;
      endcase
    end
  end

  // FSM and capture registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= CAP_A;
      porta_q <= '0;
      portb_q <= '0;
      aluop_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      porta_q <= porta_d;
      portb_q <= portb_d;
      aluop_q <= aluop_d;
      valid_q <= valid_d;
    end
  end

  assign alu.porta    = porta_q;
  assign alu.portb    = portb_q;
  assign alu.aluop    = aluop_q;
  assign alu.op_valid = valid_q;
  assign stage        = state_q;
  assign key_evt      = key_evt_q;

endmodule

// File: tb/tb_alu_operand_entry.sv
// Self-checking bench for alu_operand_entry with a run-length key model and a
// rule-level capture model, directed test-plan steps and a random key/switch phase.
module tb_alu_operand_entry;
  localparam int DEB = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [3:0]  KEY;
  logic [17:0] SW;
  logic [1:0]  stage;
  logic [3:0]  key_evt;

  alu_operand_entry_if ifc ();

  alu_operand_entry #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
    .CLK    (CLK),
    .nRST   (nRST),
    .KEY    (KEY),
    .SW     (SW),
    .alu    (ifc),
    .stage  (stage),
    .key_evt(key_evt)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc_n    = 0;
  int evt0_cnt = 0;

  // reference model state
  logic [3:0]  m_stable;
  int          m_run [4];
  logic [3:0]  evt_at [int];
  logic [17:0] m_sw1, m_sw2;
  logic [1:0]  m_st;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_op;
  logic        m_v;

  function automatic logic [3:0] evt_of(int k);
    return evt_at.exists(k) ? evt_at[k] : 4'h0;
  endfunction

  task automatic model_reset();
    m_stable = 4'hF;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    evt_at.delete();
    m_sw1 = '0;
    m_sw2 = '0;
    m_st  = 2'd0;
    m_a   = '0;
    m_b   = '0;
    m_op  = '0;
    m_v   = 1'b0;
  endtask

  // One clock edge of the model. A raw key that disagrees with the accepted level
  // for DEB consecutive samples is accepted; a press shows on key_evt 3 edges later
  // and reaches the capture logic one edge after that. Switches arrive 2 edges late.
  task automatic model_edge();
    logic [3:0]  ev;
    logic [31:0] opnd;
    if (!nRST) begin
      model_reset();
    end else begin
      ev   = evt_of(cyc_n - 1);
      opnd = {{16{m_sw2[16]}}, m_sw2[15:0]};
      if (ev[3]) begin
        m_v  = 1'b0;
        m_st = 2'd0;
      end else begin
        case (m_st)
          2'd0: if (ev[0]) begin m_a = opnd; m_st = 2'd1; end
          2'd1: if (ev[0]) begin m_b = opnd; m_st = 2'd2; end
          2'd2: if (ev[0]) begin m_op = m_sw2[3:0]; m_v = 1'b1; m_st = 2'd3; end
          default: if (m_v && ifc.op_ready) begin m_v = 1'b0; m_st = 2'd0; end
        endcase
      end
      m_sw2 = m_sw1;
      m_sw1 = SW;
      for (int i = 0; i < 4; i++) begin
        if (KEY[i] != m_stable[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_run[i] == DEB) begin
          m_run[i]    = 0;
          m_stable[i] = ~m_stable[i];
          if (!m_stable[i]) evt_at[cyc_n + 3] = evt_of(cyc_n + 3) | (4'b0001 << i);
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic check_all();
    chk("key_evt",  {28'd0, key_evt},    {28'd0, evt_of(cyc_n)});
    chk("stage",    {30'd0, stage},      {30'd0, m_st});
    chk("porta",    ifc.porta,           m_a);
    chk("portb",    ifc.portb,           m_b);
    chk("aluop",    {28'd0, ifc.aluop},  {28'd0, m_op});
    chk("op_valid", {31'd0, ifc.op_valid}, {31'd0, m_v});
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      cyc_n++;
      model_edge();
      #1;
      if (key_evt[0]) evt0_cnt++;
      check_all();
    end
  endtask

  task automatic press(input logic [3:0] mask);
    KEY = KEY & ~mask;
    cyc(10);
    KEY = KEY | mask;
    cyc(10);
  endtask

  initial begin
    int first_edge;
    int lat;
    nRST = 1'b0;
    KEY  = 4'hF;
    SW   = '0;
    ifc.op_ready = 1'b0;
    model_reset();

    // reset and idle
    cyc(3);
    chk("rst_stage", {30'd0, stage}, 32'd0);
    chk("rst_valid", {31'd0, ifc.op_valid}, 32'd0);
    nRST = 1'b1;
    evt0_cnt = 0;
    cyc(20);
    chk("idle_no_evt", evt0_cnt, 0);

    // full entry
    SW = 18'h0_0005;
    press(4'b0001);
    chk("entry_porta", ifc.porta, 32'h5);
    chk("entry_stage_b", {30'd0, stage}, 32'd1);
    SW = 18'h1_FFFE;
    press(4'b0001);
    chk("entry_portb", ifc.portb, 32'hFFFF_FFFE);
    chk("entry_stage_op", {30'd0, stage}, 32'd2);
    SW = 18'h0_0003;
    press(4'b0001);
    chk("entry_aluop", {28'd0, ifc.aluop}, 32'd3);
    chk("entry_valid", {31'd0, ifc.op_valid}, 32'd1);
    chk("entry_stage_issue", {30'd0, stage}, 32'd3);

    // handshake: ENTER ignored while waiting, then one-cycle ready
    ifc.op_ready = 1'b0;
    SW = 18'h0_0777;
    press(4'b0001);
    chk("issue_hold_valid", {31'd0, ifc.op_valid}, 32'd1);
    chk("issue_hold_porta", ifc.porta, 32'h5);
    ifc.op_ready = 1'b1;
    cyc(1);
    ifc.op_ready = 1'b0;
    chk("hs_valid_low", {31'd0, ifc.op_valid}, 32'd0);
    chk("hs_stage_a", {30'd0, stage}, 32'd0);
    cyc(4);

    // bounce rejection
    evt0_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      KEY[0] = 1'b0;
      cyc(2);
      KEY[0] = 1'b1;
      cyc(2);
    end
    cyc(10);
    chk("bounce_no_evt", evt0_cnt, 0);
    chk("bounce_stage", {30'd0, stage}, 32'd0);

    // steady press: one event at DEB+2 edges after the first low sample
    evt0_cnt   = 0;
    lat        = -1;
    KEY[0]     = 1'b0;
    first_edge = cyc_n + 1;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (key_evt[0] && lat < 0) lat = cyc_n - first_edge;
    end
    KEY[0] = 1'b1;
    cyc(12);
    chk("press_latency", lat, DEB + 2);
    chk("press_one_evt", evt0_cnt, 1);
    chk("press_stage_b", {30'd0, stage}, 32'd1);

    // clear priority in CAP_B
    press(4'b1001);
    chk("clr_stage", {30'd0, stage}, 32'd0);
    chk("clr_portb_kept", ifc.portb, 32'hFFFF_FFFE);

    // clear from ISSUE
    SW = 18'h1_8000; press(4'b0001);
    SW = 18'h0_1234; press(4'b0001);
    SW = 18'h0_000A; press(4'b0001);
    chk("issue2_valid", {31'd0, ifc.op_valid}, 32'd1);
    press(4'b1000);
    chk("clr_issue_valid", {31'd0, ifc.op_valid}, 32'd0);
    chk("clr_issue_stage", {30'd0, stage}, 32'd0);
    chk("clr_issue_aluop_kept", {28'd0, ifc.aluop}, 32'hA);

    // async reset in CAP_OP with ENTER held
    press(4'b0001);
    press(4'b0001);
    chk("pre_rst_stage", {30'd0, stage}, 32'd2);
    KEY[0] = 1'b0;
    cyc(3);
    #2;
    nRST = 1'b0;
    model_reset();
    #1;
    chk("async_porta", ifc.porta, 32'd0);
    chk("async_portb", ifc.portb, 32'd0);
    chk("async_aluop", {28'd0, ifc.aluop}, 32'd0);
    chk("async_valid", {31'd0, ifc.op_valid}, 32'd0);
    chk("async_stage", {30'd0, stage}, 32'd0);
    chk("async_evt", {28'd0, key_evt}, 32'd0);
    cyc(3);
    nRST = 1'b1;
    cyc(12);
    chk("held_key_accepted", {30'd0, stage}, 32'd1);
    KEY[0] = 1'b1;
    cyc(10);

    // random keys, switches and ready against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) KEY[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) SW = 18'($urandom);
      ifc.op_ready = 1'($urandom_range(0, 1));
      cyc(1);
    end
    KEY = 4'hF;
    ifc.op_ready = 1'b0;
    cyc(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
